// File: rtl/komb_pkg.sv
// Shared definitions for the komb automaton: input symbol codes, state encodings
// and the default debounce length used by the input stage.
package komb_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_00  = 2'b00;
    localparam sym_t SYM_01  = 2'b01;
    localparam sym_t SYM_10  = 2'b10;
    localparam sym_t SYM_CLR = 2'b11;

    // Encodings shared by the komb next-state network and its state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_S1   = 2'b01,
        ST_S2   = 2'b10,
        ST_S3   = 2'b11
    } komb_state_t;

    localparam int DEB_CYCLES_DEFAULT = 16;

    // Highest-numbered press wins; the clear symbol beats everything.
    function automatic sym_t prio_sym(input logic [3:0] press);
        if (press[3])      return SYM_CLR;
        else if (press[2]) return SYM_10;
        else if (press[1]) return SYM_01;
        else               return SYM_00;
    endfunction

endpackage

// File: rtl/komb_sym_input_btn_debounce.sv
// One push-button conditioner: two-flop synchroniser followed by a
// stability counter that only moves the debounced level after DEB_CYCLES quiet cycles.
module btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic db
);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             sb;

    assign sb = sync[1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser to one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sb == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                db  <= sb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/komb_sym_input.sv
// Input stage for komb: debounced button presses become 2-bit symbols, queued in
// a small FIFO and handed downstream over valid/ready, one symbol per press.
module komb_sym_input
    import komb_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn,
    input  logic             sym_ready,
    input  logic             ovf_clr,
    output logic             i1,
    output logic             i0,
    output logic             sym_valid,
    output logic [PTR_W:0]   fifo_level,
    output logic             overflow
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [3:0] db, db_d, press;

    for (genvar k = 0; k < 4; k++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[k]),
            .db   (db[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_d  <= '0;
            press <= '0;
        end else begin
            db_d  <= db;
            press <= db & ~db_d;
        end
    end

    sym_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   level;
    sym_t           push_sym, head;
    logic           push, clr, pop, full, accept, drop;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        push     = |press;
        clr      = press[3];
        push_sym = prio_sym(press);
        full     = (level == LVL_FULL);
        pop      = sym_valid & sym_ready;
        accept   = push & (~full | pop);
        drop     = push & full & ~pop & ~clr;
    end

    // NOTE: the symbol storage is reset along with the pointers so the head
    // never shows stale data from before a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= SYM_00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (clr) begin
                // Flush in place: the clear symbol becomes the only entry at the head.
                mem[rd_ptr] <= SYM_CLR;
                wr_ptr      <= rd_ptr + PTR_ONE;
                level       <= LVL_ONE;
            end else begin
                if (accept) begin
                    mem[wr_ptr] <= push_sym;
                    wr_ptr      <= wr_ptr + PTR_ONE;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                case ({accept, pop})
                    2'b10:   level <= level + LVL_ONE;
                    2'b01:   level <= level - LVL_ONE;
                    default: level <= level;
                endcase
            end
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign sym_valid  = (level != '0);
    assign head       = sym_valid ? mem[rd_ptr] : SYM_00;
    assign i1         = head[1];
    assign i0         = head[0];
    assign fifo_level = level;

endmodule
